// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron: FSM encoding, reset defaults,
// config register offsets and a popcount helper.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } lif_state_t;

    localparam logic [31:0] W_RST     = 32'h0000_2000;
    localparam logic [31:0] EXT_W_RST = 32'h0000_0100;
    localparam logic [31:0] VTH_RST   = 32'h0000_FC93;
    localparam logic [31:0] LEAK_RST  = 32'h0000_2000;

    // Offsets relative to N_SYN; addresses 0..N_SYN-1 are the synaptic weights.
    localparam int OFS_EXT_W   = 0;
    localparam int OFS_VTH     = 1;
    localparam int OFS_LEAK    = 2;
    localparam int OFS_REFRACT = 3;

    function automatic logic [6:0] popcount64(input logic [63:0] x);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(x[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lif_syn_accum.sv
// Combinational synaptic accumulator: weighted spike sum plus the popcount of
// the external bitstream scaled by ext_w, kept at full precision (DW+8 bits).
module lif_syn_accum
    import lif_pkg::*;
#(
    parameter int N_SYN = 8,
    parameter int EXT_W = 32,
    parameter int DW    = 32
) (
    input  logic [N_SYN-1:0]    spk,
    input  logic [EXT_W-1:0]    ext,
    input  logic [N_SYN*DW-1:0] w_flat,
    input  logic [DW-1:0]       ext_w,
    output logic signed [DW+7:0] sum
);

    localparam int ACC_W = DW + 8;

    logic [6:0]              pc;
    logic signed [ACC_W-1:0] ext_term;

    assign pc       = popcount64(64'(ext));
    assign ext_term = $signed({{(ACC_W-7){1'b0}}, pc}) * $signed({{8{ext_w[DW-1]}}, ext_w});

    // NOTE: assigning sum before the loop gives every path a value, so no latch is inferred.
    always_comb begin
        sum = ext_term;
        for (int i = 0; i < N_SYN; i++) begin
            if (spk[i]) begin
                sum = sum + $signed({{8{w_flat[i*DW+DW-1]}}, w_flat[i*DW +: DW]});
            end
        end
    end

endmodule

// File: rtl/lif_neuron_gen.sv
// Leaky integrate-and-fire neuron with a writable config bank and an
// INTEGRATE / FIRE / REFRACT state machine.
module lif_neuron_gen
    import lif_pkg::*;
#(
    parameter int N_SYN       = 8,
    parameter int EXT_W       = 32,
    parameter int DW          = 32,
    parameter int REFRACT_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_SYN-1:0]           spk_in,
    input  logic [EXT_W-1:0]           ext_in,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SYN+4)-1:0] cfg_addr,
    input  logic [DW-1:0]              cfg_wdata,
    output logic [DW-1:0]              vout,
    output logic                       spike,
    output logic [15:0]                spike_cnt,
    output logic [1:0]                 state
);

    localparam int AW    = $clog2(N_SYN + 4);
    localparam int ACC_W = DW + 8;
    localparam logic signed [ACC_W-1:0] V_MAX =
        $signed({{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}});

    logic signed [DW-1:0] w [N_SYN];
    logic [N_SYN*DW-1:0]  w_flat;
    logic [DW-1:0]        ext_w;
    logic signed [DW-1:0] vth;
    logic signed [DW-1:0] leak;
    logic [7:0]           refract;

    lif_state_t           st;
    logic signed [DW-1:0] v;
    logic [7:0]           rcnt;

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] v_acc;
    logic signed [DW-1:0]    v_next;
    logic                    fire;

    for (genvar i = 0; i < N_SYN; i++) begin : g_wflat
        assign w_flat[i*DW +: DW] = w[i];
    end

    lif_syn_accum #(.N_SYN(N_SYN), .EXT_W(EXT_W), .DW(DW)) u_accum (
        .spk    (spk_in),
        .ext    (ext_in),
        .w_flat (w_flat),
        .ext_w  (ext_w),
        .sum    (sum)
    );

    // Non-zero input integrates with saturation; an idle cycle leaks toward zero.
    always_comb begin
        if (sum != '0) begin
            v_acc = {{8{v[DW-1]}}, v} + sum;
        end else begin
            v_acc = {{8{v[DW-1]}}, v} - {{8{leak[DW-1]}}, leak};
        end
        if (v_acc < 0) begin
            v_next = '0;
        end else if (v_acc > V_MAX) begin
            v_next = V_MAX[DW-1:0];
        end else begin
            v_next = v_acc[DW-1:0];
        end
    end

    assign fire = (v_next >= vth);

    // NOTE: the weight array is a handful of flops with defined reset values, not a RAM, so it is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                w[i] <= DW'(W_RST);
            end
            ext_w   <= DW'(EXT_W_RST);
            vth     <= DW'(VTH_RST);
            leak    <= DW'(LEAK_RST);
            refract <= 8'(REFRACT_RST);
        end else if (cfg_we) begin
            for (int i = 0; i < N_SYN; i++) begin
                if (cfg_addr == AW'(i)) begin
                    w[i] <= cfg_wdata;
                end
            end
            if (cfg_addr == AW'(N_SYN + OFS_EXT_W))   ext_w   <= cfg_wdata;
            if (cfg_addr == AW'(N_SYN + OFS_VTH))     vth     <= cfg_wdata;
            if (cfg_addr == AW'(N_SYN + OFS_LEAK))    leak    <= cfg_wdata;
            if (cfg_addr == AW'(N_SYN + OFS_REFRACT)) refract <= cfg_wdata[7:0];
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= ST_INTEGRATE;
            v         <= '0;
            spike     <= 1'b0;
            spike_cnt <= '0;
            rcnt      <= '0;
        end else if (en) begin
            case (st)
                ST_INTEGRATE: begin
                    v <= v_next;
                    if (fire) begin
                        st    <= ST_FIRE;
                        spike <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    v     <= '0;
                    spike <= 1'b0;
                    if (spike_cnt != 16'hFFFF) spike_cnt <= spike_cnt + 16'd1;
                    // Refractory length is latched here so later writes affect only the next period.
                    if (refract != 8'd0) begin
                        st   <= ST_REFRACT;
                        rcnt <= refract - 8'd1;
                    end else begin
                        st <= ST_INTEGRATE;
                    end
                end
                ST_REFRACT: begin
                    v <= '0;
                    if (rcnt == 8'd0) begin
                        st <= ST_INTEGRATE;
                    end else begin
                        rcnt <= rcnt - 8'd1;
                    end
                end
                default: begin
                    st    <= ST_INTEGRATE;
                    v     <= '0;
                    spike <= 1'b0;
                end
            endcase
        end
    end

    assign vout  = v;
    assign state = st;

endmodule

// File: doc/lif_neuron_gen.md
LIF_NEURON_GEN -- requirements
Module: lif_neuron_gen

Interface
REQ-001 SHALL have parameter N_SYN, default 8, number of single-bit synaptic spike inputs (1..32).
REQ-002 SHALL have parameter EXT_W, default 32, width of the external rate-coded bitstream input (1..64).
REQ-003 SHALL have parameter DW, default 32, width of signed Q16.16 membrane/weight values (16..32).
REQ-004 SHALL have parameter REFRACT_RST, default 1, reset value of the refractory length in cycles (0..255).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port en, input, 1, advances neuron state when high.
REQ-009 SHALL have port spk_in, input, N_SYN, synaptic spikes; bit i uses weight w[i].
REQ-010 SHALL have port ext_in, input, EXT_W, bitstream; the popcount is used.
REQ-011 SHALL have port cfg_we, input, 1, config write strobe.
REQ-012 SHALL have port cfg_addr, input, clog2(N_SYN+4), config register index.
REQ-013 SHALL have port cfg_wdata, input, DW, config write data.
REQ-014 SHALL have port vout, output, DW, registered membrane potential v.
REQ-015 SHALL have port spike, output, 1, high exactly while in FIRE.
REQ-016 SHALL have port spike_cnt, output, 16, saturating count of fired spikes.
REQ-017 SHALL have port state, output, 2, current FSM state.

Function
REQ-018 SHALL map config registers as follows: 0..N_SYN-1 = w[i] (signed); N_SYN = ext_w; N_SYN+1 = vth; N_SYN+2 = leak; N_SYN+3 = refract (bits [7:0]); writes to any other address SHALL be ignored.
REQ-019 SHALL apply a config write on the clock edge where cfg_we=1, regardless of en or state, and the new value SHALL take effect from the next cycle's computation.
REQ-020 SHALL implement FSM states INTEGRATE=0, FIRE=1, REFRACT=2.
REQ-021 SHALL hold all state, v, counters and spike_cnt when en=0; config writes remain accepted.
REQ-022 SHALL compute in INTEGRATE each cycle: sum = sigma(spk_in[i]*w[i]) + popcount(ext_in)*ext_w, using a full-precision signed accumulator.
REQ-023 SHALL, when sum != 0, set v_next = clamp(v+sum, 0, 2^(DW-1)-1).
REQ-024 SHALL, when sum == 0, set v_next = max(v-leak, 0).
REQ-025 SHALL register v <= v_next at the edge, and SHALL move to FIRE at that same edge if v_next >= vth; spike latency SHALL be 1 cycle after the crossing edge.
REQ-026 SHALL, in FIRE, ignore inputs, set v <= 0, increment spike_cnt (saturating at 0xFFFF), and move to REFRACT if refract>0, otherwise to INTEGRATE.
REQ-027 SHALL, in REFRACT, ignore inputs, hold v=0, and count refract cycles before returning to INTEGRATE.
REQ-028 SHALL apply the REFRACT length read at FIRE exit; changing refract mid-REFRACT SHALL NOT affect the current period.
REQ-029 SHALL treat vth <= 0 as firing on every INTEGRATE cycle.
REQ-030 SHALL update vout with v, mirroring it on every edge.

Reset
REQ-031 SHALL, while rst=0, set state=INTEGRATE, v=vout=0, spike=0, spike_cnt=0, and the refractory counter to 0.
REQ-032 SHALL, on reset, set w[i]=0x00002000, ext_w=0x00000100, vth=0x0000FC93, leak=0x00002000, and refract=REFRACT_RST.
REQ-033 SHALL abort FIRE or REFRACT when reset is asserted in those states, with no spike_cnt increment.

Structure
REQ-034 SHALL place the state encoding, reset-default constants, and config address offsets in shared package lif_pkg.
REQ-035 SHALL contain one combinational sub-module, lif_syn_accum (weighted sum plus popcount scaling), parametrised by N_SYN, EXT_W and DW.

Verification
REQ-036 SHALL verify, with defaults and spk_in=0xFF, ext_in=0: after edge 1 v=0x10000; spike=1 in cycle 2; REFRACT for 1 cycle; INTEGRATE from cycle 4; spike_cnt=1.
REQ-037 SHALL verify, with defaults, spk_in=0, ext_in=0x0000FFFF: v rises by 0x1000 per cycle, crosses at edge 16 (0x10000), and spike is asserted in cycle 17.
REQ-038 SHALL verify leak: a single pulse spk_in=0x07 gives v=0x6000, then with inputs idle v=0x4000, 0x2000, 0, 0.
REQ-039 SHALL verify inhibition: w[0]=0xFFFFC000 with v=0x2000 and spk_in=0x01 clamps v to 0; no spike.
REQ-040 SHALL verify saturation: all w=0x7FFFFFFF, vth=0x7FFFFFFF, spk_in=0xFF gives v=0x7FFFFFFF and a spike the next cycle.
REQ-041 SHALL verify reset mid-REFRACT (refract=5; rst low at cycle 2 of REFRACT): state=INTEGRATE, spike_cnt=0, config registers at defaults.
